// File: rtl/gru_seq_ctrl_if.sv
// gru_seq_ctrl_if: sample-in / hidden-state-out handshake bundle for gru_seq_ctrl.
interface gru_seq_ctrl_if #(parameter int DW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl: sequences samples through an external combinational GRU cell, carrying h across steps.
// Optional GRU_SEQ_LAST_CLR_EN: the hidden state restarts at 0 after a step flagged last.
module gru_seq_ctrl #(
  parameter int DW     = 8,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  gru_seq_ctrl_if.slave   bus,
  output logic [DW-1:0]   cell_x,
  output logic [DW-1:0]   cell_h,
  input  logic [DW-1:0]   cell_hout,
  output logic            busy
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          last;
  logic [DW-1:0] h_next;

  assign bus.in_ready  = state == ST_IDLE;
  assign bus.out_valid = state == ST_OUT;
  assign busy          = state != ST_IDLE;

`ifdef GRU_SEQ_LAST_CLR_EN
  assign h_next = last ? '0 : cell_hout;
`else
  assign h_next = cell_hout;
`endif

  // cell_h is the hidden-state register itself, so it only moves at the capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      last         <= 1'b0;
      cell_x       <= '0;
      cell_h       <= '0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (bus.in_valid) begin
        cell_x <= bus.in_data;
        last   <= bus.in_last;
        cnt    <= 4'(SETTLE - 1);
        state  <= ST_SETTLE;
      end
    end else if (state == ST_SETTLE) begin
      if (cnt == 4'd0) begin
        bus.out_data <= cell_hout;
        bus.out_last <= last;
        cell_h       <= h_next;
        state        <= ST_OUT;
      end else
        cnt <= cnt - 4'd1;
    end else if (bus.out_ready)
      state <= ST_IDLE;
  end
endmodule

// File: tb/tb_gru_seq_ctrl.sv
// tb_gru_seq_ctrl: scoreboard bench for gru_seq_ctrl with a stub cell h_out = x + h (mod 2^8).
module tb_gru_seq_ctrl;
`ifdef GRU_SEQ_LAST_CLR_EN
  localparam bit LCLR = 1'b1;
`else
  localparam bit LCLR = 1'b0;
`endif
  typedef struct packed { logic last; logic [7:0] data; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, busy;
  logic [7:0] cell_x, cell_h, cell_hout, h_model;
  int errors = 0, checks = 0, cyc = 0;
  exp_t sbq[$];

  gru_seq_ctrl_if #(.DW(8)) bus ();
  gru_seq_ctrl #(.DW(8), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cell_x(cell_x), .cell_h(cell_h),
    .cell_hout(cell_hout), .busy(busy));

  assign cell_hout = cell_x + cell_h;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sbq.delete();
    h_model = 8'h00;
  endtask

  task automatic send(input logic [7:0] x, input logic l, output int acc);
    int n = 0;
    exp_t e;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b1; bus.in_data = x; bus.in_last = l;
    acc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e.data = x + h_model; e.last = l;
    sbq.push_back(e);
    h_model = (LCLR && l) ? 8'h00 : e.data;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!bus.out_valid && c < 50) begin @(posedge clk); #1; c++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_held busy=%b out_valid=%b want 0 0", busy, bus.out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++;
    if ({bus.out_valid, busy, bus.out_last} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.out_valid, busy, bus.out_last}); end
    checks++;
    if ({bus.out_data, cell_x, cell_h} !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", {bus.out_data, cell_x, cell_h}); end
    h_model = 8'h00;
  endtask

  task automatic test_basic();
    logic [7:0] xs [2];
    int acc, c;
    exp_t e;
    xs[0] = 8'h10; xs[1] = 8'h11;
    for (int i = 0; i < 2; i++) begin
      send(xs[i], 1'b0, acc);
      checks++;
      if (cell_h !== (i == 0 ? 8'h00 : 8'h10)) begin errors++; $display("FAIL basic_cell_h[%0d] got %h want %h", i, cell_h, i == 0 ? 8'h00 : 8'h10); end
      wait_out(c);
      checks++;
      if (c !== 2) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 2", i, c); end
      checks++;
      if (cell_x !== xs[i]) begin errors++; $display("FAIL basic_cell_x[%0d] got %h want %h", i, cell_x, xs[i]); end
      e = sbq.pop_front();
      checks++;
      if ({bus.out_last, bus.out_data} !== e) begin errors++; $display("FAIL basic_out[%0d] got %h want %h", i, {bus.out_last, bus.out_data}, e); end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_back_idle[%0d] busy=%b want 0", i, busy); end
    end
    checks++;
    if (h_model !== 8'h21) begin errors++; $display("FAIL basic_model got %h want 21", h_model); end
  endtask

  task automatic test_backpressure();
    int acc, c;
    exp_t e;
    bus.out_ready = 1'b0;
    send(8'h01, 1'b0, acc);
    wait_out(c);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_last, bus.out_data} !== {2'b10, sbq[0]}) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b r=%b %h want v=1 r=0 %h", i, bus.out_valid, bus.in_ready, {bus.out_last, bus.out_data}, sbq[0]);
      end
      checks++;
      if (cell_x !== 8'h01) begin errors++; $display("FAIL bp_cell_x[%0d] got %h want 01", i, cell_x); end
    end
    bus.in_valid = 1'b0;
    e = sbq.pop_front();
    checks++;
    if ({bus.out_last, bus.out_data} !== e) begin errors++; $display("FAIL bp_out got %h want %h", {bus.out_last, bus.out_data}, e); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release busy/in_ready got %b want 01", {busy, bus.in_ready}); end
  endtask

  task automatic test_last();
    int acc, c;
    exp_t e;
    do_reset();
    send(8'h10, 1'b1, acc);
    wait_out(c);
    e = sbq.pop_front();
    checks++;
    if ({bus.out_last, bus.out_data} !== e || e !== {1'b1, 8'h10}) begin errors++; $display("FAIL last_first got %h want 110", {bus.out_last, bus.out_data}); end
    @(posedge clk); #1;
    send(8'h05, 1'b0, acc);
    wait_out(c);
    e = sbq.pop_front();
    checks++;
    if ({bus.out_last, bus.out_data} !== e) begin errors++; $display("FAIL last_second got %h want %h", {bus.out_last, bus.out_data}, e); end
    checks++;
    if (bus.out_data !== (LCLR ? 8'h05 : 8'h15)) begin errors++; $display("FAIL last_carry got %h want %h", bus.out_data, LCLR ? 8'h05 : 8'h15); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int acc, c;
    bit seen = 1'b0;
    exp_t e;
    do_reset();
    send(8'h20, 1'b0, acc);
    wait_out(c);
    void'(sbq.pop_front());
    @(posedge clk); #1;
    send(8'h10, 1'b0, acc);
    checks++;
    if (cell_h !== 8'h20) begin errors++; $display("FAIL rmid_prior_h got %h want 20", cell_h); end
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({busy, cell_h} !== 9'h000) begin errors++; $display("FAIL rmid_async got busy=%b h=%h want 0 00", busy, cell_h); end
    @(posedge clk); #1 rst_n = 1'b1;
    sbq.delete(); h_model = 8'h00;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; seen |= bus.out_valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_out out_valid seen=%b want 0", seen); end
    send(8'h03, 1'b0, acc);
    wait_out(c);
    e = sbq.pop_front();
    checks++;
    if ({bus.out_last, bus.out_data} !== e || bus.out_data !== 8'h03) begin errors++; $display("FAIL rmid_next got %h want 003", {bus.out_last, bus.out_data}); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int acc, c;
    exp_t e;
    logic [7:0] want [2];
    want[0] = 8'h80; want[1] = 8'h00;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(8'h80, 1'b0, acc);
      wait_out(c);
      e = sbq.pop_front();
      checks++;
      if ({bus.out_last, bus.out_data} !== e || bus.out_data !== want[i]) begin errors++; $display("FAIL wrap[%0d] got %h want %h", i, bus.out_data, want[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int acc, prev, c;
    exp_t e;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h07 * (i + 1)), i == 3, acc);
      if (i > 0) begin
        checks++;
        if (acc - prev !== 4) begin errors++; $display("FAIL b2b_period[%0d] got %0d want 4", i, acc - prev); end
      end
      prev = acc;
      wait_out(c);
      checks++;
      if (c !== 2) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 2", i, c); end
      e = sbq.pop_front();
      checks++;
      if ({bus.out_last, bus.out_data} !== e) begin errors++; $display("FAIL b2b_out[%0d] got %h want %h", i, {bus.out_last, bus.out_data}, e); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    h_model = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_last();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gru_seq_ctrl.md
GRU_SEQ_CTRL -- requirements
Module: gru_seq_ctrl

Interface
REQ-001 Parameter: DW, default 8, width of the signed hidden state and sample (two's complement).
REQ-002 Parameter: SETTLE, default 2, cycles allowed for the combinational cell to settle; legal range 1..15.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input sample X is valid.
REQ-006 in_ready  output  1  controller accepts a sample this cycle.
REQ-007 in_data  input  DW  signed sample X.
REQ-008 in_last  input  1  sample is the last of its sequence.
REQ-009 cell_x  output  DW  registered X driven to the cell's X port.
REQ-010 cell_h  output  DW  registered hidden state driven to the cell's h_in port.
REQ-011 cell_hout  input  DW  the cell's h_out.
REQ-012 out_valid  output  1  out_data holds a new hidden state.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_data  output  DW  captured h_out of the current step.
REQ-015 out_last  output  1  out_data belongs to a sample accepted with in_last=1.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SETTLE, OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-018 IDLE: on in_valid&&in_ready, latch in_data into cell_x and in_last into a last flag, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-019 SETTLE: decrement the counter each cycle; on the edge where the counter is 0, capture cell_hout into out_data and into the hidden-state register, and go to OUT.
REQ-020 out_valid SHALL rise exactly SETTLE cycles after the accepting edge (SETTLE=2: 2 cycles).
REQ-021 cell_x and cell_h SHALL remain stable from the accepting edge through the capture edge.
REQ-022 OUT: hold out_data/out_last stable while out_ready=0; on out_valid&&out_ready go to IDLE; the next sample is accepted no earlier than the following edge (peak throughput one sample per SETTLE+2 cycles).
REQ-023 The hidden-state register SHALL update only at the capture edge; cell_h SHALL follow it, so step n+1 uses h_out of step n.
REQ-024 All values are passed bit-exact; no arithmetic, saturation or rounding is performed.
REQ-025 in_valid while not in IDLE SHALL be ignored (no accept, no state change).

Reset
REQ-026 While rst_n=0: state=IDLE, cell_x=0, cell_h=0, hidden state=0, out_data=0, out_last=0, out_valid=0, busy=0, counter=0; in_ready SHALL be 1 after release.
REQ-027 Reset asserted mid-SETTLE or mid-OUT SHALL discard the step with no capture; the first step after release uses h=0.

Configuration
REQ-028 Macro GRU_SEQ_LAST_CLR_EN: when defined, the capture edge of a step with the last flag set SHALL still output cell_hout on out_data but SHALL load 0 into the hidden state, so the next sequence starts from h=0.
REQ-029 Without GRU_SEQ_LAST_CLR_EN, in_last SHALL only propagate to out_last, and the hidden state always carries over.

Verification (stub cell: cell_hout = cell_x + cell_h, mod 2^DW; DW=8, SETTLE=2)
REQ-030 Reset held, then released -> all outputs 0 except in_ready=1; busy=0.
REQ-031 Accept X=0x10 with out_ready=1 -> cell_h=0x00, out_valid 2 cycles later with out_data=0x10; then X=0x11 -> out_data=0x21.
REQ-032 out_ready=0 for 5 cycles in OUT -> out_data stays stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-033 Macro defined: X=0x10 with in_last=1, then X=0x05 -> out_data 0x10 (out_last=1), then 0x05; macro undefined: same stimulus -> 0x10, then 0x15.
REQ-034 rst_n pulsed low during SETTLE of X=0x10 after a prior h=0x20 -> no out_valid; next X=0x03 yields out_data=0x03.
REQ-035 Inputs X=0x80 then X=0x80 -> out_data 0x80, then 0x00 (wrap, no saturation).
